// File: rtl/gat_pkg.sv
// Shared constants and FSM encoding for the GAT core's new-feature drain path.
package gat_pkg;

  localparam int NEW_FEATURE_WIDTH  = 32;
  localparam int NUM_SUBGRAPHS      = 2708;
  localparam int NUM_FEATURE_OUT    = 16;
  localparam int NEW_FEATURE_DEPTH  = NUM_SUBGRAPHS * NUM_FEATURE_OUT;
  localparam int NEW_FEATURE_ADDR_W = $clog2(NEW_FEATURE_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_WAIT_RDY = 3'd1,
    S_ISSUE    = 3'd2,
    S_DRAIN    = 3'd3,
    S_DONE     = 3'd4
  } rd_state_e;

endpackage

// File: rtl/feat_stream_reader_if.sv
// AXI4-Stream style bus carrying drained feature words plus first/last markers.
interface feat_stream_reader_if #(
  parameter int W = 32
) ();
  // A beat transfers on a cycle where tvalid && tready; once tvalid is high the
  // source holds tdata/tlast/tuser stable until that transfer happens.
  logic [W-1:0] tdata;
  logic         tvalid;
  logic         tready;
  logic         tlast;
  logic         tuser;

  modport master (output tdata, output tvalid, output tlast, output tuser, input tready);
  modport slave  (input tdata, input tvalid, input tlast, input tuser, output tready);
endinterface

// File: rtl/feat_rd_fifo.sv
// Small synchronous FIFO that absorbs read data landing while the sink stalls.
module feat_rd_fifo #(
  parameter int WIDTH = 34,
  parameter int DEPTH = 4,
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign full  = (count_q == CNT_W'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;
  assign rdata = mem_q[rd_ptr_q];

  always_comb begin
    do_pop   = pop && !empty;
    // A push into a full FIFO is accepted only when a pop frees the slot.
    do_push  = push && (!full || do_pop);
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = wdata;
      wr_ptr_d        = ptr_inc(wr_ptr_q);
    end
    if (do_pop) rd_ptr_d = ptr_inc(rd_ptr_q);
    if (do_push && !do_pop)      count_d = count_q + CNT_W'(1);
    else if (do_pop && !do_push) count_d = count_q - CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/feat_stream_reader.sv
// Sweeps the new-feature BRAM after a layer completes and streams every word out
// in address order, issuing reads only when the skid FIFO has room for them.
module feat_stream_reader #(
  parameter int NEW_FEATURE_WIDTH  = gat_pkg::NEW_FEATURE_WIDTH,
  parameter int NUM_SUBGRAPHS      = gat_pkg::NUM_SUBGRAPHS,
  parameter int NUM_FEATURE_OUT    = gat_pkg::NUM_FEATURE_OUT,
  parameter int NEW_FEATURE_DEPTH  = NUM_SUBGRAPHS * NUM_FEATURE_OUT,
  parameter int NEW_FEATURE_ADDR_W = $clog2(NEW_FEATURE_DEPTH),
  parameter int RD_LATENCY         = 2,
  parameter int FIFO_DEPTH         = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  input  logic                          gat_ready,
  output logic                          busy,
  output logic                          done,
  output logic [NEW_FEATURE_ADDR_W+1:0] feat_bram_addrb,
  input  logic [NEW_FEATURE_WIDTH-1:0]  feat_bram_dout,
  feat_stream_reader_if.master          m_axis,
  output gat_pkg::rd_state_e            dbg_state
);
  import gat_pkg::*;

  localparam int FC_W  = (NUM_FEATURE_OUT > 1) ? $clog2(NUM_FEATURE_OUT) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int FW    = NEW_FEATURE_WIDTH + 2;
  localparam logic [NEW_FEATURE_ADDR_W-1:0] LAST_IDX = NEW_FEATURE_ADDR_W'(NEW_FEATURE_DEPTH - 1);
  localparam logic [FC_W-1:0]               LAST_FC  = FC_W'(NUM_FEATURE_OUT - 1);

  rd_state_e                     state_q, state_d;
  logic [NEW_FEATURE_ADDR_W-1:0] idx_q, idx_d;
  logic [FC_W-1:0]               fcnt_q, fcnt_d;
  logic [RD_LATENCY-1:0]         pv_q, pv_d, pu_q, pu_d, pl_q, pl_d;
  logic                          issue, credit_ok, drain_done, last_idx;
  logic [CNT_W-1:0]              fifo_count;
  logic                          fifo_full, fifo_empty, fifo_pop;
  logic [FW-1:0]                 fifo_rdata;
  int                            inflight;

  // Every valid tag in the pipeline already owns a FIFO slot it will land in.
  always_comb begin
    inflight = 0;
    for (int i = 0; i < RD_LATENCY; i++) inflight = inflight + (pv_q[i] ? 1 : 0);
  end

  assign last_idx   = (idx_q == LAST_IDX);
  assign credit_ok  = ((inflight + int'(fifo_count) + 1) <= FIFO_DEPTH) && !fifo_full;
  assign fifo_pop   = m_axis.tvalid && m_axis.tready;
  // Finishing on the pop of the last entry lets done land one cycle after tlast.
  assign drain_done = (inflight == 0) &&
                      (fifo_empty || ((fifo_count == CNT_W'(1)) && fifo_pop));

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    fcnt_d  = fcnt_q;
    issue   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_WAIT_RDY;
          idx_d   = '0;
          fcnt_d  = '0;
        end
      end
      S_WAIT_RDY: if (gat_ready) state_d = S_ISSUE;
      S_ISSUE: begin
        if (credit_ok) begin
          issue  = 1'b1;
          fcnt_d = (fcnt_q == LAST_FC) ? '0 : fcnt_q + FC_W'(1);
          if (last_idx) state_d = S_DRAIN;
          else          idx_d   = idx_q + NEW_FEATURE_ADDR_W'(1);
        end
      end
      S_DRAIN: if (drain_done) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    pv_d    = pv_q;
    pu_d    = pu_q;
    pl_d    = pl_q;
    pv_d[0] = issue;
    pu_d[0] = (fcnt_q == '0);
    pl_d[0] = last_idx;
    for (int i = 1; i < RD_LATENCY; i++) begin
      pv_d[i] = pv_q[i-1];
      pu_d[i] = pu_q[i-1];
      pl_d[i] = pl_q[i-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      fcnt_q  <= '0;
      pv_q    <= '0;
      pu_q    <= '0;
      pl_q    <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      fcnt_q  <= fcnt_d;
      pv_q    <= pv_d;
      pu_q    <= pu_d;
      pl_q    <= pl_d;
    end
  end

  feat_rd_fifo #(
    .WIDTH (FW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (pv_q[RD_LATENCY-1]),
    .wdata ({pu_q[RD_LATENCY-1], pl_q[RD_LATENCY-1], feat_bram_dout}),
    .pop   (fifo_pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign m_axis.tvalid = !fifo_empty;
  assign m_axis.tdata  = fifo_rdata[NEW_FEATURE_WIDTH-1:0];
  assign m_axis.tlast  = fifo_rdata[NEW_FEATURE_WIDTH];
  assign m_axis.tuser  = fifo_rdata[NEW_FEATURE_WIDTH+1];
  assign busy            = (state_q != S_IDLE);
  assign done            = (state_q == S_DONE);
  assign feat_bram_addrb = {idx_q, 2'b00};
  assign dbg_state       = state_q;

endmodule

// File: tb/tb_feat_stream_reader.sv
// Bench for feat_stream_reader: a 2x4-word layer read back through latency 2,
// plus latency-1 and latency-3 instances for the timing sweep.
module tb_feat_stream_reader;
  import gat_pkg::*;

  localparam int W   = 32;
  localparam int NSG = 2;
  localparam int NFO = 4;
  localparam int AW  = 3;

  typedef struct {
    logic [AW+1:0] addr;
    logic [W-1:0]  data;
    logic          user;
    logic          last;
  } beat_t;

  beat_t      vec [8];
  logic [W-1:0] exp_q [$];
  int         total = 0;
  int         bad   = 0;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic start_x = 1'b0;
  logic gat_ready = 1'b0;
  logic tready = 1'b1;
  logic pat [4];
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUTs (latency 2 main, 1 and 3 for the sweep) ----------------
  feat_stream_reader_if #(.W(W)) ax0 ();
  feat_stream_reader_if #(.W(W)) ax1 ();
  feat_stream_reader_if #(.W(W)) ax2 ();
  assign ax0.tready = tready;
  assign ax1.tready = tready;
  assign ax2.tready = tready;

  logic [AW+1:0] addrb [3];
  logic [W-1:0]  dout [3];
  logic          busy_w [3];
  logic          done_w [3];
  rd_state_e     st_w [3];

  feat_stream_reader #(.NEW_FEATURE_WIDTH(W), .NUM_SUBGRAPHS(NSG), .NUM_FEATURE_OUT(NFO),
                       .RD_LATENCY(2), .FIFO_DEPTH(4)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .gat_ready(gat_ready),
    .busy(busy_w[0]), .done(done_w[0]), .feat_bram_addrb(addrb[0]),
    .feat_bram_dout(dout[0]), .m_axis(ax0), .dbg_state(st_w[0]));

  feat_stream_reader #(.NEW_FEATURE_WIDTH(W), .NUM_SUBGRAPHS(NSG), .NUM_FEATURE_OUT(NFO),
                       .RD_LATENCY(1), .FIFO_DEPTH(4)) u_dut_l1 (
    .clk(clk), .rst_n(rst_n), .start(start_x), .gat_ready(gat_ready),
    .busy(busy_w[1]), .done(done_w[1]), .feat_bram_addrb(addrb[1]),
    .feat_bram_dout(dout[1]), .m_axis(ax1), .dbg_state(st_w[1]));

  feat_stream_reader #(.NEW_FEATURE_WIDTH(W), .NUM_SUBGRAPHS(NSG), .NUM_FEATURE_OUT(NFO),
                       .RD_LATENCY(3), .FIFO_DEPTH(4)) u_dut_l3 (
    .clk(clk), .rst_n(rst_n), .start(start_x), .gat_ready(gat_ready),
    .busy(busy_w[2]), .done(done_w[2]), .feat_bram_addrb(addrb[2]),
    .feat_bram_dout(dout[2]), .m_axis(ax2), .dbg_state(st_w[2]));

  // ---------------- BRAM models: word i holds 0x100+i ----------------
  logic [AW+1:0] ap0 [2] = '{default: '0};
  logic [AW+1:0] ap1 [1] = '{default: '0};
  logic [AW+1:0] ap2 [3] = '{default: '0};

  function automatic logic [W-1:0] bram_word(input logic [AW+1:0] a);
    return 32'h100 + 32'(a[AW+1:2]);
  endfunction

  always @(posedge clk) begin
    ap0[0] <= addrb[0]; ap0[1] <= ap0[0];
    ap1[0] <= addrb[1];
    ap2[0] <= addrb[2]; ap2[1] <= ap2[0]; ap2[2] <= ap2[1];
  end
  assign dout[0] = bram_word(ap0[1]);
  assign dout[1] = bram_word(ap1[0]);
  assign dout[2] = bram_word(ap2[2]);

  // ---------------- monitor ----------------
  logic         tv [3], tu [3], tl [3];
  logic [W-1:0] td [3];
  assign tv[0] = ax0.tvalid; assign tu[0] = ax0.tuser; assign tl[0] = ax0.tlast; assign td[0] = ax0.tdata;
  assign tv[1] = ax1.tvalid; assign tu[1] = ax1.tuser; assign tl[1] = ax1.tlast; assign td[1] = ax1.tdata;
  assign tv[2] = ax2.tvalid; assign tu[2] = ax2.tuser; assign tl[2] = ax2.tlast; assign td[2] = ax2.tdata;

  logic [W-1:0]  got_data [3][$];
  logic          got_user [3][$];
  logic          got_last [3][$];
  int            beat_cyc [3][$];
  int            done_cyc [3][$];
  int            done_cnt [3] = '{default: 0};
  int            issue_cyc [3] = '{default: 0};
  logic          in_issue [3] = '{default: 1'b0};
  logic [AW+1:0] addr_log [$];
  int            stall_err = 0;
  int            stall_seen = 0;
  logic          stall_prev = 1'b0;
  logic [W-1:0]  stall_data = '0;

  always @(negedge clk) begin
    for (int d = 0; d < 3; d++) begin
      if (tv[d] && tready) begin
        got_data[d].push_back(td[d]);
        got_user[d].push_back(tu[d]);
        got_last[d].push_back(tl[d]);
        beat_cyc[d].push_back(cyc);
      end
      if (done_w[d]) begin
        done_cnt[d] = done_cnt[d] + 1;
        done_cyc[d].push_back(cyc);
      end
      if (st_w[d] == S_ISSUE && !in_issue[d]) issue_cyc[d] = cyc;
      in_issue[d] = (st_w[d] == S_ISSUE);
    end
    if (st_w[0] == S_ISSUE && (addr_log.size() == 0 || addr_log[$] != addrb[0]))
      addr_log.push_back(addrb[0]);
    if (stall_prev) begin
      stall_seen = stall_seen + 1;
      if (!tv[0] || td[0] != stall_data) stall_err = stall_err + 1;
    end
    stall_prev = tv[0] && !tready;
    stall_data = td[0];
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", name, got, exp);
    end
  endtask

  task automatic start_sweep(input int d);
    if (d == 0) start = 1'b1;
    else        start_x = 1'b1;
    tick();
    start = 1'b0;
    start_x = 1'b0;
  endtask

  task automatic run_until_done(input int d, input int budget, input bit bp);
    int base = done_cnt[d];
    int k = 0;
    while (done_cnt[d] == base && k < budget) begin
      if (bp) tready = pat[k % 4];
      tick();
      k++;
      if (bp) begin
        total++;
        if (u_dut.fifo_count > 4) begin
          bad++;
          $display("FAIL fifo_count: got=%0d max=4", u_dut.fifo_count);
        end
      end
    end
    tready = 1'b1;
    total++;
    if (done_cnt[d] == base) begin
      bad++;
      $display("FAIL timeout_dut%0d: no done within %0d cycles", d, budget);
    end
    repeat (4) tick();
  endtask

  task automatic wait_beats(input int d, input int n, input int budget);
    int k = 0;
    while (got_data[d].size() < n && k < budget) begin
      tick();
      k++;
    end
    check($sformatf("wait_beats_dut%0d", d), (got_data[d].size() >= n), 1);
  endtask

  // ---------------- scoreboard ----------------
  task automatic check_sweep(input int d, input int bb, input int db, input string pfx, input bit full_rate);
    int n = got_data[d].size() - bb;
    logic [W-1:0] e;
    check({pfx, "_beats"}, n, 8);
    for (int i = 0; i < 8; i++) exp_q.push_back(vec[i].data);
    for (int i = 0; i < 8; i++) begin
      if (i < n) begin
        e = exp_q.pop_front();
        check($sformatf("%s_tdata%0d", pfx, i), got_data[d][bb+i], e);
        check($sformatf("%s_tuser%0d", pfx, i), got_user[d][bb+i], vec[i].user);
        check($sformatf("%s_tlast%0d", pfx, i), got_last[d][bb+i], vec[i].last);
        if (full_rate && d == 0)
          check($sformatf("%s_beatcyc%0d", pfx, i), beat_cyc[d][bb+i] - beat_cyc[d][bb], i);
      end
    end
    exp_q.delete();
    check({pfx, "_done_count"}, done_cnt[d] - db, 1);
    if (full_rate && n > 0) begin
      check({pfx, "_first_latency"}, beat_cyc[d][bb] - issue_cyc[d], (d == 0) ? 3 : (d == 1) ? 2 : 4);
      if (d == 0 && n >= 8 && done_cnt[d] > db)
        check({pfx, "_done_after_last"}, done_cyc[d][db] - beat_cyc[d][bb+7], 1);
    end
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int bb, db, ab, se, ss, d1, d2, b1, b2, k, dc;
    vec[0] = '{5'h00, 32'h100, 1'b1, 1'b0};
    vec[1] = '{5'h04, 32'h101, 1'b0, 1'b0};
    vec[2] = '{5'h08, 32'h102, 1'b0, 1'b0};
    vec[3] = '{5'h0C, 32'h103, 1'b0, 1'b0};
    vec[4] = '{5'h10, 32'h104, 1'b1, 1'b0};
    vec[5] = '{5'h14, 32'h105, 1'b0, 1'b0};
    vec[6] = '{5'h18, 32'h106, 1'b0, 1'b0};
    vec[7] = '{5'h1C, 32'h107, 1'b0, 1'b1};
    pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b0; pat[3] = 1'b1;

    repeat (3) tick();
    check("rst_busy",   busy_w[0], 0);
    check("rst_done",   done_w[0], 0);
    check("rst_addrb",  addrb[0], 0);
    check("rst_tvalid", tv[0], 0);
    check("rst_tdata",  td[0], 0);
    check("rst_tlast",  tl[0], 0);
    check("rst_tuser",  tu[0], 0);
    check("rst_state",  st_w[0], S_IDLE);
    rst_n = 1'b1;
    tick();

    // Full rate
    gat_ready = 1'b1;
    bb = got_data[0].size(); db = done_cnt[0]; ab = addr_log.size();
    start_sweep(0);
    run_until_done(0, 200, 1'b0);
    check_sweep(0, bb, db, "full", 1'b1);
    check("full_addr_count", addr_log.size() - ab, 8);
    for (int i = 0; i < 8; i++)
      if (ab + i < addr_log.size())
        check($sformatf("full_addrb%0d", i), addr_log[ab+i], vec[i].addr);
    check("full_idle_busy", busy_w[0], 0);

    // Backpressure 1,0,0,1
    bb = got_data[0].size(); db = done_cnt[0]; se = stall_err; ss = stall_seen;
    start_sweep(0);
    run_until_done(0, 400, 1'b1);
    check_sweep(0, bb, db, "bp", 1'b0);
    check("bp_tdata_stable", stall_err - se, 0);
    check("bp_stalls_seen", (stall_seen - ss) > 0, 1);

    // Ready gating
    gat_ready = 1'b0;
    bb = got_data[0].size(); db = done_cnt[0];
    start_sweep(0);
    for (int i = 0; i < 10; i++) begin
      check($sformatf("gate_addrb%0d", i), addrb[0], 0);
      check($sformatf("gate_tvalid%0d", i), tv[0], 0);
      check($sformatf("gate_busy%0d", i), busy_w[0], 1);
      tick();
    end
    gat_ready = 1'b1;
    run_until_done(0, 200, 1'b0);
    check_sweep(0, bb, db, "gate", 1'b1);

    // Start pulse mid-sweep is ignored
    bb = got_data[0].size(); db = done_cnt[0];
    start_sweep(0);
    wait_beats(0, bb + 3, 100);
    start_sweep(0);
    run_until_done(0, 200, 1'b0);
    repeat (20) tick();
    check_sweep(0, bb, db, "ign", 1'b1);
    check("ign_idle_busy", busy_w[0], 0);

    // Reset mid-sweep
    bb = got_data[0].size();
    start_sweep(0);
    wait_beats(0, bb + 3, 100);
    dc = done_cnt[0];
    rst_n = 1'b0;
    #1;
    check("midrst_busy",   busy_w[0], 0);
    check("midrst_done",   done_w[0], 0);
    check("midrst_addrb",  addrb[0], 0);
    check("midrst_tvalid", tv[0], 0);
    check("midrst_tdata",  td[0], 0);
    check("midrst_tlast",  tl[0], 0);
    check("midrst_tuser",  tu[0], 0);
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (10) tick();
    check("midrst_no_done", done_cnt[0] - dc, 0);
    bb = got_data[0].size(); db = done_cnt[0];
    start_sweep(0);
    run_until_done(0, 200, 1'b0);
    check_sweep(0, bb, db, "replay", 1'b1);

    // Latency 1 and 3 instances
    b1 = got_data[1].size(); d1 = done_cnt[1];
    b2 = got_data[2].size(); d2 = done_cnt[2];
    start_sweep(1);
    k = 0;
    while ((done_cnt[1] == d1 || done_cnt[2] == d2) && k < 300) begin
      tick();
      k++;
    end
    check("lat_both_done", (done_cnt[1] > d1) && (done_cnt[2] > d2), 1);
    repeat (4) tick();
    check_sweep(1, b1, d1, "lat1", 1'b1);
    check_sweep(2, b2, d2, "lat3", 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
